// File: rtl/lut_wvf_loader.sv
// Stream loader for the external waveform LUT: fills a register table from a valid/ready
// stream and flags LUT_VALID once complete. Optional checksum beat: LUT_LOADER_CHECKSUM_EN.
module lut_wvf_loader #(
    parameter int LUT_WIDTH = 32,
    parameter int BIT_WIDTH = 12
) (
    input  logic                           CLK_SYS,
    input  logic                           nRST,
    input  logic                           START,
    input  logic [BIT_WIDTH-1:0]           DATA_IN,
    input  logic                           DATA_VALID,
    output logic                           DATA_READY,
    output logic [$clog2(LUT_WIDTH)-1:0]   ADDR,
    output logic                           BUSY,
    output logic                           LUT_VALID,
    output logic                           ERR,
    output logic [BIT_WIDTH*LUT_WIDTH-1:0] LUT_ROM
);
    // state | meaning
    // IDLE  | after reset, waiting for START
    // LOAD  | accepting table words
    // CHECK | accepting the checksum word (checksum build only)
    // DONE  | table complete (or checksum failed), held until START
    localparam int AW = $clog2(LUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
`ifdef LUT_LOADER_CHECKSUM_EN
        CHECK = 2'd3,
`endif
        DONE  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [BIT_WIDTH*LUT_WIDTH-1:0] rom_q, rom_d;
    logic                         ready_q, ready_d;
    logic                         busy_q, busy_d;
    logic                         lut_valid_q, lut_valid_d;
    logic                         hs;

`ifdef LUT_LOADER_CHECKSUM_EN
    logic [BIT_WIDTH-1:0]         sum_q, sum_d;
    logic                         err_q, err_d;
`endif

    assign hs = DATA_VALID & ready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rom_d       = rom_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        lut_valid_d = lut_valid_q;
`ifdef LUT_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif
        // START wins over everything, including a coincident data beat
        if (START) begin
            state_d     = LOAD;
            addr_d      = '0;
            ready_d     = 1'b1;
            busy_d      = 1'b1;
            lut_valid_d = 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
            sum_d       = '0;
            err_d       = 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (hs) begin
                        for (int i = 0; i < LUT_WIDTH; i++) begin
                            if (addr_q == AW'(i)) rom_d[i*BIT_WIDTH +: BIT_WIDTH] = DATA_IN;
                        end
`ifdef LUT_LOADER_CHECKSUM_EN
                        sum_d = sum_q + DATA_IN;
`endif
                        if (addr_q == AW'(LUT_WIDTH - 1)) begin
                            addr_d = '0;
`ifdef LUT_LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d     = DONE;
                            ready_d     = 1'b0;
                            busy_d      = 1'b0;
                            lut_valid_d = 1'b1;
`endif
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
`ifdef LUT_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (hs) begin
                        state_d     = DONE;
                        ready_d     = 1'b0;
                        busy_d      = 1'b0;
                        lut_valid_d = (DATA_IN == sum_q);
                        err_d       = (DATA_IN != sum_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rom_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            lut_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rom_q       <= rom_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            lut_valid_q <= lut_valid_d;
        end
    end

`ifdef LUT_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign DATA_READY = ready_q;
    assign ADDR       = addr_q;
    assign BUSY       = busy_q;
    assign LUT_VALID  = lut_valid_q;
    assign LUT_ROM    = rom_q;

endmodule

// File: tb/tb_lut_wvf_loader.sv
// Directed bench for lut_wvf_loader at LUT_WIDTH=4, BIT_WIDTH=8; checksum steps run when
// LUT_LOADER_CHECKSUM_EN is defined.
module tb_lut_wvf_loader;
    logic        CLK_SYS = 1'b0;
    logic        nRST;
    logic        START;
    logic [7:0]  DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [1:0]  ADDR;
    logic        BUSY;
    logic        LUT_VALID;
    logic        ERR;
    logic [31:0] LUT_ROM;

    int checks   = 0;
    int failures = 0;

    lut_wvf_loader #(.LUT_WIDTH(4), .BIT_WIDTH(8)) dut (
        .CLK_SYS    (CLK_SYS),
        .nRST       (nRST),
        .START      (START),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .ADDR       (ADDR),
        .BUSY       (BUSY),
        .LUT_VALID  (LUT_VALID),
        .ERR        (ERR),
        .LUT_ROM    (LUT_ROM)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    // state flags packed as {BUSY, DATA_READY, LUT_VALID, ERR}
    function automatic logic [31:0] flags();
        return {28'd0, BUSY, DATA_READY, LUT_VALID, ERR};
    endfunction

    initial begin
        nRST = 1'b0; START = 1'b0; DATA_VALID = 1'b0; DATA_IN = 8'h00;
        #12;
        chk("reset_rom", LUT_ROM, 32'h0);
        chk("reset_flags", flags(), 32'h0);
        chk("reset_addr", {30'd0, ADDR}, 32'd0);
        nRST = 1'b1;
        tick();
        chk("idle_flags", flags(), 32'h0);

        // back-to-back full load
        START = 1'b1; tick(); START = 1'b0;
        chk("load_start_flags", flags(), 32'hC);
        chk("load_start_addr", {30'd0, ADDR}, 32'd0);
        DATA_VALID = 1'b1;
        DATA_IN = 8'h10; tick();
        chk("b2b_addr1", {30'd0, ADDR}, 32'd1);
        chk("b2b_rom1", LUT_ROM, 32'h00000010);
        DATA_IN = 8'h20; tick();
        DATA_IN = 8'h30; tick();
        chk("b2b_pre_last_valid", flags(), 32'hC);
        DATA_IN = 8'h40; tick();
`ifdef LUT_LOADER_CHECKSUM_EN
        chk("b2b_check_flags", flags(), 32'hC);
        DATA_IN = 8'hA0; tick();
`endif
        chk("b2b_rom", LUT_ROM, 32'h40302010);
        chk("b2b_done_flags", flags(), 32'h2);
        chk("b2b_done_addr", {30'd0, ADDR}, 32'd0);
        DATA_IN = 8'h55; tick();
        DATA_VALID = 1'b0;
        chk("b2b_fifth_rom", LUT_ROM, 32'h40302010);
        chk("b2b_fifth_flags", flags(), 32'h2);

        // restart over a done table: old contents visible until overwritten
        START = 1'b1; tick(); START = 1'b0;
        chk("restart_flags", flags(), 32'hC);
        chk("restart_rom_kept", LUT_ROM, 32'h40302010);
        DATA_VALID = 1'b1; DATA_IN = 8'h11; tick(); DATA_VALID = 1'b0;
        chk("restart_rom_one", LUT_ROM, 32'h40302011);
        chk("restart_addr", {30'd0, ADDR}, 32'd1);

        // stalled load, 3 idle cycles between words
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            DATA_VALID = 1'b1; DATA_IN = 8'(8'h10 * (i + 1)); tick(); DATA_VALID = 1'b0;
            if (i < 3) begin
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("stall_addr_%0d_%0d", i, k), {30'd0, ADDR}, 32'(i + 1));
                    chk($sformatf("stall_valid_%0d_%0d", i, k), {31'd0, LUT_VALID}, 32'd0);
                end
            end
        end
`ifdef LUT_LOADER_CHECKSUM_EN
        DATA_VALID = 1'b1; DATA_IN = 8'hA0; tick(); DATA_VALID = 1'b0;
`endif
        chk("stall_rom", LUT_ROM, 32'h40302010);
        chk("stall_done_flags", flags(), 32'h2);

        // START coinciding with a data beat discards the beat
        START = 1'b1; tick(); START = 1'b0;
        DATA_VALID = 1'b1;
        DATA_IN = 8'hAA; tick();
        DATA_IN = 8'hBB; tick();
        START = 1'b1; DATA_IN = 8'hCC; tick(); START = 1'b0;
        chk("discard_addr", {30'd0, ADDR}, 32'd0);
        chk("discard_rom", LUT_ROM, 32'h4030BBAA);
        chk("discard_flags", flags(), 32'hC);
        for (int i = 1; i <= 4; i++) begin
            DATA_IN = 8'(i); tick();
        end
`ifdef LUT_LOADER_CHECKSUM_EN
        DATA_IN = 8'h0A; tick();
`endif
        DATA_VALID = 1'b0;
        chk("discard_final_rom", LUT_ROM, 32'h04030201);
        chk("discard_final_flags", flags(), 32'h2);

`ifdef LUT_LOADER_CHECKSUM_EN
        // checksum mismatch then recovery
        START = 1'b1; tick(); START = 1'b0;
        DATA_VALID = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            DATA_IN = 8'(8'h10 * i); tick();
        end
        DATA_IN = 8'hA1; tick(); DATA_VALID = 1'b0;
        chk("cks_bad_flags", flags(), 32'h1);
        tick();
        chk("cks_err_held", flags(), 32'h1);
        START = 1'b1; tick(); START = 1'b0;
        chk("cks_err_cleared", flags(), 32'hC);
`endif

        // asynchronous reset mid-session, no clock edge needed
        START = 1'b1; tick(); START = 1'b0;
        DATA_VALID = 1'b1; DATA_IN = 8'h77; tick(); DATA_VALID = 1'b0;
        chk("mid_addr", {30'd0, ADDR}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("async_rst_rom", LUT_ROM, 32'h0);
        chk("async_rst_flags", flags(), 32'h0);
        chk("async_rst_addr", {30'd0, ADDR}, 32'd0);
        @(negedge CLK_SYS);
        nRST = 1'b1;
        tick();
        chk("post_rst_flags", flags(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
